// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates.
// Optional macro CLKDIV_SYNC_EN adds sync_in to phase-align every channel at once.
module prog_clock_divider #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 15_000_000,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    input  logic                div_load,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_value,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic sync;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] act_q, act_d;
        logic [WIDTH-1:0] shd_q, shd_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d;
        logic             clk_q, tick_q;
        logic             run, hit, last;

        assign run  = (act_q >= WIDTH'(2)) && ch_en[i];
        assign hit  = div_load && (32'(div_sel) == 32'(i));
        assign last = run && (cnt_q >= act_q - WIDTH'(1));

        // Shadow divisor is promoted only at a period boundary, a sync, or while idle
        always_comb begin
            act_d  = act_q;
            shd_d  = shd_q;
            cnt_d  = cnt_q;
            pend_d = pend_q;
            if (sync || !run || last) begin
                cnt_d = '0;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            if (hit) begin
                shd_d  = div_value;
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                act_q  <= WIDTH'(DEFAULT_DIV);
                shd_q  <= WIDTH'(DEFAULT_DIV);
                cnt_q  <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                act_q  <= act_d;
                shd_q  <= shd_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                clk_q  <= run && (cnt_q >= (act_q >> 1));
                tick_q <= last;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent divider channels, range 1..16.
REQ-002 SHALL have parameter WIDTH, default 24: divisor and counter width in bits, range 2..32.
REQ-003 SHALL have parameter DEFAULT_DIV, default 15_000_000: divisor loaded into every channel at reset; must fit in WIDTH bits.
REQ-004 SHALL have port clk_in, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port div_load, input, 1 bit: one-cycle divisor write strobe.
REQ-007 SHALL have port div_sel, input, max(1,$clog2(CHANNELS)) bits: target channel of the write.
REQ-008 SHALL have port div_value, input, WIDTH bits: new divisor D (period in clk_in cycles).
REQ-009 SHALL have port ch_en, input, CHANNELS bits: per-channel run enable.
REQ-010 SHALL have port clk_out, output, CHANNELS bits: per-channel divided square wave, registered.
REQ-011 SHALL have port tick, output, CHANNELS bits: one-cycle pulse per period, registered.
REQ-012 SHALL have port pending, output, CHANNELS bits: high while a written divisor is not yet active.

Function
REQ-013 Each channel SHALL hold an active divisor A, a shadow divisor S, a counter cnt[WIDTH-1:0] and a pending flag.
REQ-014 Channel running (A>=2, ch_en=1): cnt counts 0..A-1 and then wraps to 0; the period is exactly A cycles.
REQ-015 Channel running: the registered clk_out SHALL be 0 when cnt<floor(A/2) and 1 otherwise. Odd A gives a high phase one cycle longer than the low phase.
REQ-016 Channel running: the registered tick SHALL be 1 in the cycle after cnt==A-1, and 0 in all other cycles.
REQ-017 clk_out and tick SHALL both have a one-cycle latency from cnt; no combinational path from any input to any output.
REQ-018 div_load=1 with div_sel<CHANNELS SHALL write div_value into S of that channel and set its pending flag in the next cycle.
REQ-019 div_load=1 with div_sel>=CHANNELS SHALL be ignored.
REQ-020 A second write to a channel while pending=1 SHALL overwrite S; only the last value is applied.
REQ-021 Pending divisor, channel running: S->A SHALL occur on the wrap cycle (cnt==A-1 -> 0) and pending SHALL clear. No truncated or stretched period is allowed (glitch-free switch).
REQ-022 Pending divisor, channel stopped (A<2 or ch_en=0): S->A SHALL occur in the next cycle with cnt=0, and pending SHALL clear.
REQ-023 If a write lands in the same cycle as the wrap, the wrap SHALL apply the old S; the new value SHALL become pending.
REQ-024 A<2 SHALL disable the channel: cnt=0, clk_out=0, tick=0.
REQ-025 ch_en=0 SHALL hold cnt at 0 and force clk_out=0 and tick=0.
REQ-026 On ch_en 0->1, counting SHALL restart from cnt=0.
REQ-027 Channels SHALL be fully independent; writes to one channel SHALL NOT disturb any other channel's phase.

Reset
REQ-028 rst=1 SHALL asynchronously set, for every channel: A=S=DEFAULT_DIV, cnt=0, pending=0, clk_out=0, tick=0.
REQ-029 Reset mid-period or while pending SHALL discard the pending value.
REQ-030 On the first rising edge after rst deasserts, every enabled channel SHALL start from cnt=0.

Configuration
REQ-031 Macro CLKDIV_SYNC_EN defined: adds port sync_in (input, 1 bit).
REQ-032 With CLKDIV_SYNC_EN, sync_in=1 SHALL, in the next cycle, set cnt=0 in all channels and apply every pending S->A, phase-aligning all channels.
REQ-033 With CLKDIV_SYNC_EN, sync_in SHALL take priority over a wrap and over div_load in the same cycle; the write is still captured as pending.
REQ-034 Macro CLKDIV_SYNC_EN undefined: sync_in is absent and behaviour is exactly REQ-013..REQ-030.

Verification
REQ-035 Reset, CHANNELS=2, DEFAULT_DIV=4, ch_en=2'b11 -> each clk_out follows 0,0,1,1 repeating; tick pulses every 4 cycles.
REQ-036 Load D=5 into ch0 mid-period -> pending=1 until the wrap; next period clk_out is 0,0,1,1,1; ch1 timing unchanged.
REQ-037 Load D=1, then D=0 into ch1 -> clk_out[1]=0 and tick[1]=0 constantly; loading D=6 then yields a period of 6 starting from cnt=0.
REQ-038 Write ch0 D=8 then D=3 before the wrap -> only D=3 takes effect; pending clears at the wrap; div_sel=3 with CHANNELS=2 -> no effect.
REQ-039 ch_en[0] low for 7 cycles, then high -> clk_out[0]=0 while low; a full period restarts from cnt=0.
REQ-040 Assert rst mid-period with a pending write -> outputs go to 0 immediately; DEFAULT_DIV is restored; the pending value is lost. With CLKDIV_SYNC_EN, a sync_in pulse -> all tick outputs coincide A cycles later.
